// File: rtl/anita3_evt_defs.sv
// anita3_evt_defs
//   Shared definitions for the event header writer: header word indices,
//   word count, FSM state encodings, buffer-half address bit and the
//   latched trigger record type.
//   Optional feature macro: ANITA3_EVT_CHECKSUM_EN (adds checksum word 9).
package anita3_evt_defs;

  localparam int unsigned BUF_ADDR_BIT = 6;

  localparam logic [3:0] W_HDR    = 4'd0;
  localparam logic [3:0] W_EVT_LO = 4'd1;
  localparam logic [3:0] W_EVT_HI = 4'd2;
  localparam logic [3:0] W_PPS    = 4'd3;
  localparam logic [3:0] W_CLK_LO = 4'd4;
  localparam logic [3:0] W_CLK_HI = 4'd5;
  localparam logic [3:0] W_L3     = 4'd6;
  localparam logic [3:0] W_PHI    = 4'd7;
  localparam logic [3:0] W_DEAD   = 4'd8;
  localparam logic [3:0] W_CKSUM  = 4'd9;

`ifdef ANITA3_EVT_CHECKSUM_EN
  localparam logic [3:0] NW         = W_CKSUM + 4'd1;
  localparam logic       CKSUM_FLAG = 1'b1;
`else
  // Without the checksum the header stops just before the checksum slot.
  localparam logic [3:0] NW         = W_CKSUM;
  localparam logic       CKSUM_FLAG = 1'b0;
`endif

  localparam logic [3:0] W_LAST = NW - 4'd1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  typedef struct packed {
    logic [31:0] evt_num;
    logic [15:0] pps_num;
    logic [31:0] clk_count;
    logic [15:0] l3_pattern;
    logic [15:0] phi_mask;
    logic [15:0] deadtime;
  } evt_rec_t;

endpackage

// File: rtl/anita3_evt_occupancy.sv
// anita3_evt_occupancy
//   Counts buffer halves holding unread events (0..2).
//   Ports:
//     clk33_i, rst_i  clock, async active-high reset
//     inc             writer finished an event (done pulse)
//     dec             reader released a half
//     occupancy       current count
//     full_nxt        count will be 2 after this edge (feeds registered ready)
//     release_err     sticky: release seen while count was 0
module anita3_evt_occupancy (
  input  logic       clk33_i,
  input  logic       rst_i,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] occupancy,
  output logic       full_nxt,
  output logic       release_err
);

  logic [1:0] occ_q;
  logic [1:0] occ_nxt;
  logic       dec_ok;

  // A release with nothing stored is ignored (and flagged), so a coincident
  // done at count 0 still increments.
  assign dec_ok = dec && (occ_q != 2'd0);

  always_comb begin
    occ_nxt = occ_q;
    unique case ({inc, dec_ok})
      2'b10:   occ_nxt = (occ_q == 2'd2) ? 2'd2 : occ_q + 2'd1;
      2'b01:   occ_nxt = occ_q - 2'd1;
      default: occ_nxt = occ_q;
    endcase
  end

  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q       <= '0;
      release_err <= 1'b0;
    end else begin
      occ_q <= occ_nxt;
      if (dec && (occ_q == 2'd0))
        release_err <= 1'b1;
    end
  end

  assign occupancy = occ_q;
  assign full_nxt  = (occ_nxt == 2'd2);

endmodule

// File: rtl/anita3_event_header_writer.sv
// anita3_event_header_writer
//   Accepts one trigger record per event (valid/ready), writes it as fixed
//   16-bit header words into the current ping-pong half (addr bit 6), then
//   pulses event_done_o and toggles the half. Stalls while both halves hold
//   unread events.
//   Ports: clk33_i/rst_i (async active-high); evt_valid_i/evt_ready_o record
//   handshake with field inputs evt_num_i..deadtime_i; event_wr_addr_o,
//   event_wr_dat_o, event_wr_o RAM write port; event_done_o end-of-event pulse;
//   buf_release_i reader release; occupancy_o, release_err_o status.
//   Optional feature macro: ANITA3_EVT_CHECKSUM_EN (word 9 = sum of words 0..8).
module anita3_event_header_writer #(
  parameter logic [7:0] HDR_VERSION = 8'h03
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [31:0] evt_num_i,
  input  logic [15:0] pps_num_i,
  input  logic [31:0] clk_count_i,
  input  logic [15:0] l3_pattern_i,
  input  logic [15:0] phi_mask_i,
  input  logic [15:0] deadtime_i,
  output logic [7:0]  event_wr_addr_o,
  output logic [15:0] event_wr_dat_o,
  output logic        event_wr_o,
  output logic        event_done_o,
  input  logic        buf_release_i,
  output logic [1:0]  occupancy_o,
  output logic        release_err_o
);
  import anita3_evt_defs::*;

  logic [1:0]  state;
  logic [3:0]  word;
  logic        half_sel;
  logic        ready_q;
  logic        full_nxt;
  logic        accept;
  logic        done_pulse;
  logic [15:0] word_dat;
  evt_rec_t    rec;
`ifdef ANITA3_EVT_CHECKSUM_EN
  logic [15:0] cksum_q;
`endif

  assign accept     = evt_valid_i && ready_q;
  assign done_pulse = (state == ST_DONE);

  anita3_evt_occupancy u_occ (
    .clk33_i     (clk33_i),
    .rst_i       (rst_i),
    .inc         (done_pulse),
    .dec         (buf_release_i),
    .occupancy   (occupancy_o),
    .full_nxt    (full_nxt),
    .release_err (release_err_o)
  );

  // ready is registered so it stays low through reset and rises on the first
  // edge after; it is recomputed from next-cycle occupancy whenever the FSM
  // will sit in IDLE, so it always equals (IDLE && occupancy<2) afterwards.
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      word     <= '0;
      half_sel <= 1'b0;
      ready_q  <= 1'b0;
      rec      <= '0;
`ifdef ANITA3_EVT_CHECKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rec.evt_num    <= evt_num_i;
            rec.pps_num    <= pps_num_i;
            rec.clk_count  <= clk_count_i;
            rec.l3_pattern <= l3_pattern_i;
            rec.phi_mask   <= phi_mask_i;
            rec.deadtime   <= deadtime_i;
            word           <= W_HDR;
            state          <= ST_WRITE;
`ifdef ANITA3_EVT_CHECKSUM_EN
            cksum_q        <= '0;
`endif
          end else begin
            ready_q <= !full_nxt;
          end
        end
        ST_WRITE: begin
          word <= word + 4'd1;
`ifdef ANITA3_EVT_CHECKSUM_EN
          cksum_q <= cksum_q + word_dat;
`endif
          if (word == W_LAST)
            state <= ST_DONE;
        end
        ST_DONE: begin
          half_sel <= ~half_sel;
          state    <= ST_IDLE;
          ready_q  <= !full_nxt;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_dat = '0;
    case (word)
      W_HDR:    word_dat = {HDR_VERSION, 6'b0, CKSUM_FLAG, half_sel};
      W_EVT_LO: word_dat = rec.evt_num[15:0];
      W_EVT_HI: word_dat = rec.evt_num[31:16];
      W_PPS:    word_dat = rec.pps_num;
      W_CLK_LO: word_dat = rec.clk_count[15:0];
      W_CLK_HI: word_dat = rec.clk_count[31:16];
      W_L3:     word_dat = rec.l3_pattern;
      W_PHI:    word_dat = rec.phi_mask;
      W_DEAD:   word_dat = rec.deadtime;
`ifdef ANITA3_EVT_CHECKSUM_EN
      W_CKSUM:  word_dat = cksum_q;
`endif
      default:  word_dat = '0;
    endcase
  end

  always_comb begin
    event_wr_o      = (state == ST_WRITE);
    event_done_o    = done_pulse;
    evt_ready_o     = ready_q;
    event_wr_dat_o  = '0;
    event_wr_addr_o = '0;
    if (state == ST_WRITE) begin
      event_wr_dat_o               = word_dat;
      event_wr_addr_o[5:0]         = {2'b00, word};
      event_wr_addr_o[BUF_ADDR_BIT] = half_sel;
    end else if (state == ST_DONE) begin
      event_wr_addr_o[BUF_ADDR_BIT] = half_sel;
    end
  end

endmodule

// File: tb/tb_anita3_event_header_writer.sv
module tb_anita3_event_header_writer;

`ifdef ANITA3_EVT_CHECKSUM_EN
  localparam int   NW = 10;
  localparam logic CK = 1'b1;
`else
  localparam int   NW = 9;
  localparam logic CK = 1'b0;
`endif
  localparam logic [15:0] HF = CK ? 16'h0002 : 16'h0000;

  typedef struct {
    logic [31:0] evt;
    logic [15:0] pps;
    logic [31:0] clkc;
    logic [15:0] l3;
    logic [15:0] phi;
    logic [15:0] dead;
  } fld_t;

  typedef struct {
    fld_t        f;
    logic [15:0] exp [9];
    bit          half;
  } vec_t;

  logic        clk, rst, evt_valid, evt_ready, buf_rel;
  logic [31:0] evt_num, clk_count;
  logic [15:0] pps_num, l3_pattern, phi_mask, deadtime;
  logic [7:0]  wr_addr;
  logic [15:0] wr_dat;
  logic        wr, done, rel_err;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int          m_occ, m_t;
  bit          m_err, m_half, m_busy, m_fresh, m_acc;
  logic [15:0] m_words [10];
  logic [15:0] ram [256];
  bit          written [256];

  anita3_event_header_writer #(.HDR_VERSION(8'h03)) dut (
    .clk33_i        (clk),
    .rst_i          (rst),
    .evt_valid_i    (evt_valid),
    .evt_ready_o    (evt_ready),
    .evt_num_i      (evt_num),
    .pps_num_i      (pps_num),
    .clk_count_i    (clk_count),
    .l3_pattern_i   (l3_pattern),
    .phi_mask_i     (phi_mask),
    .deadtime_i     (deadtime),
    .event_wr_addr_o(wr_addr),
    .event_wr_dat_o (wr_dat),
    .event_wr_o     (wr),
    .event_done_o   (done),
    .buf_release_i  (buf_rel),
    .occupancy_o    (occ),
    .release_err_o  (rel_err)
  );

  initial begin
    clk = 1'b0;
    forever #15 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Header words straight from the word map.
  function automatic void build(input fld_t f, input bit h);
    logic [15:0] s;
    m_words[0] = {8'h03, 6'b0, CK, h};
    m_words[1] = f.evt[15:0];
    m_words[2] = f.evt[31:16];
    m_words[3] = f.pps;
    m_words[4] = f.clkc[15:0];
    m_words[5] = f.clkc[31:16];
    m_words[6] = f.l3;
    m_words[7] = f.phi;
    m_words[8] = f.dead;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + m_words[i];
    m_words[9] = s;
  endfunction

  function automatic fld_t rnd_fld();
    fld_t f;
    f.evt  = $urandom;
    f.pps  = 16'($urandom);
    f.clkc = $urandom;
    f.l3   = 16'($urandom);
    f.phi  = 16'($urandom);
    f.dead = 16'($urandom);
    return f;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit v, input bit rel, input fld_t f);
    bit e_ready, e_wr, e_done;
    logic [7:0] e_addr;
    int occ_old;
    evt_valid  = v;
    buf_rel    = rel;
    evt_num    = f.evt;
    pps_num    = f.pps;
    clk_count  = f.clkc;
    l3_pattern = f.l3;
    phi_mask   = f.phi;
    deadtime   = f.dead;
    @(negedge clk);
    e_ready = !m_fresh && !m_busy && (m_occ < 2);
    e_wr    = m_busy && (m_t <= NW);
    e_done  = m_busy && (m_t == NW + 1);
    chk("ready", evt_ready, e_ready);
    chk("wr", wr, e_wr);
    chk("done", done, e_done);
    if (e_wr) begin
      e_addr = {1'b0, m_half, 6'(m_t - 1)};
      chk("addr", wr_addr, e_addr);
      chk("data", wr_dat, m_words[m_t - 1]);
    end
    if (e_done) chk("done_half", wr_addr[6], m_half);
    chk("occupancy", occ, m_occ);
    chk("release_err", rel_err, m_err);
    if (wr === 1'b1) begin
      ram[wr_addr]     = wr_dat;
      written[wr_addr] = 1'b1;
    end
    m_acc   = v && e_ready;
    occ_old = m_occ;
    if (rel && occ_old == 0) m_err = 1'b1;
    m_occ = occ_old + (e_done ? 1 : 0) - ((rel && occ_old != 0) ? 1 : 0);
    if (e_done) begin
      m_half = !m_half;
      m_busy = 1'b0;
    end else if (m_busy) m_t++;
    if (m_acc) begin
      build(f, m_half);
      m_busy = 1'b1;
      m_t    = 1;
    end
    m_fresh = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #5 rst = 1'b1;
    #1;
    chk("rst_ready", evt_ready, 0);
    chk("rst_wr", wr, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_dat", wr_dat, 0);
    chk("rst_occ", occ, 0);
    chk("rst_err", rel_err, 0);
    evt_valid = 1'b0;
    buf_rel   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_occ = 0; m_err = 0; m_half = 0; m_busy = 0; m_t = 0; m_acc = 0;
    m_fresh = 1'b1;
  endtask

  task automatic wait_idle();
    fld_t z;
    z = '{default: '0};
    for (int k = 0; k < 20 && m_busy; k++) step(1'b0, 1'b0, rnd_fld());
    if (m_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic send(input fld_t f);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, f);
      if (m_acc) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    wait_idle();
  endtask

  vec_t tbl [3];
  fld_t zf;

  initial begin
    rst = 1'b1; evt_valid = 1'b0; buf_rel = 1'b0;
    evt_num = '0; pps_num = '0; clk_count = '0;
    l3_pattern = '0; phi_mask = '0; deadtime = '0;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; written[i] = 1'b0; end
    zf = '{default: '0};

    tbl[0].f = '{32'h12345678, 16'h0042, 32'h0000BEEF, 16'hA5A5, 16'h0F0F, 16'h1111};
    tbl[0].exp = '{16'h0300 | HF, 16'h5678, 16'h1234, 16'h0042, 16'hBEEF,
                   16'h0000, 16'hA5A5, 16'h0F0F, 16'h1111};
    tbl[0].half = 1'b0;
    tbl[1].f = '{32'hDEADBEEF, 16'hFFFF, 32'h89ABCDEF, 16'h0001, 16'h8000, 16'h7FFF};
    tbl[1].exp = '{16'h0301 | HF, 16'hBEEF, 16'hDEAD, 16'hFFFF, 16'hCDEF,
                   16'h89AB, 16'h0001, 16'h8000, 16'h7FFF};
    tbl[1].half = 1'b1;
    tbl[2].f = zf;
    tbl[2].exp = '{16'h0300 | HF, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[2].half = 1'b0;

    @(posedge clk);
    #1;
    do_reset();

    // Table: records 0 and 1 fill both halves; record 2 stalls until a release.
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        chk("full_ready_low", evt_ready, 0);
        chk("full_occ", occ, 2);
        for (int k = 0; k < 40; k++) begin
          step(1'b1, k == 5, tbl[i].f);
          if (m_acc) break;
        end
        if (!m_acc) chk("stall_accept_timeout", 0, 1);
        wait_idle();
      end else begin
        send(tbl[i].f);
      end
      for (int w = 0; w < 9; w++)
        chk($sformatf("tbl%0d_w%0d", i, w), ram[{1'b0, tbl[i].half, 6'(w)}], tbl[i].exp[w]);
      chk($sformatf("tbl%0d_occ", i), occ, (i == 0) ? 1 : 2);
    end
`ifdef ANITA3_EVT_CHECKSUM_EN
    chk("cksum_written", written[8'h09], 1);
    chk("cksum_zero_rec", ram[8'h09], 16'h0302);
`else
    chk("no_write_09", written[8'h09], 0);
    chk("no_write_49", written[8'h49], 0);
`endif

    // Drain, then release coincident with done at occupancy 1.
    step(1'b0, 1'b1, zf);
    step(1'b0, 1'b1, zf);
    chk("drained_occ", occ, 0);
    send(rnd_fld());
    chk("one_occ", occ, 1);
    begin
      fld_t f;
      f = rnd_fld();
      for (int k = 0; k < 40 && !m_acc; k++) step(1'b1, 1'b0, f);
      for (int k = 0; k < 20 && m_busy; k++) step(1'b0, m_t == NW + 1, rnd_fld());
    end
    chk("coincident_occ", occ, 1);

    // Release at zero occupancy.
    step(1'b0, 1'b1, zf);
    chk("pre_err", rel_err, 0);
    step(1'b0, 1'b1, zf);
    chk("err_set", rel_err, 1);
    chk("err_occ", occ, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, zf);
    chk("err_sticky", rel_err, 1);

    // Abort mid-WRITE at word 4.
    begin
      fld_t f;
      f = rnd_fld();
      for (int k = 0; k < 40 && !m_acc; k++) step(1'b1, 1'b0, f);
      for (int k = 0; k < 20 && m_t != 5; k++) step(1'b0, 1'b0, rnd_fld());
      chk("pre_abort_wr", wr, 1);
      chk("pre_abort_addr", wr_addr, 8'h44);
    end
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, zf);
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    send(rnd_fld());
    chk("restart_half0", written[8'h00], 1);
    chk("restart_not_half1", written[8'h40], 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, rnd_fld());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
